// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory arbiter: FSM states, requester ids,
// RAM window defaults and the address-fault check.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IFU = 1'b0,
    PORT_LSU = 1'b1
  } port_e;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] MEM_SIZE_DEFAULT = 32'h0000_2024;

  // The upper bound is formed in 33 bits so a window touching the top of the
  // address space cannot wrap around.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
    logic [32:0] limit;
    limit = {1'b0, base} + {1'b0, size};
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the RAM.
interface mem_arbiter_if;

  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rdata;
  logic        ifu_rsp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_we;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata;
  logic        lsu_rsp_valid;
  logic        lsu_rsp_ready;
  logic [31:0] lsu_rdata;
  logic        lsu_rsp_err;

  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;

  // Arbiter side.
  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_rsp_ready,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    input  lsu_req_valid, lsu_addr, lsu_we, lsu_be, lsu_wdata, lsu_rsp_ready,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    output ram_en, ram_we, ram_addr, ram_wd,
    input  ram_rd
  );

  // Requester and RAM side.
  modport master (
    output ifu_req_valid, ifu_addr, ifu_rsp_ready,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    output lsu_req_valid, lsu_addr, lsu_we, lsu_be, lsu_wdata, lsu_rsp_ready,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    input  ram_en, ram_we, ram_addr, ram_wd,
    output ram_rd
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between IFU and LSU with a last-grant register.
module rr_arb2
  import mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  req_ifu,
  input  logic  req_lsu,
  output logic  gnt_valid,
  output port_e grant,
  output port_e last_grant
);

  port_e last_q;

  always_comb begin
    grant = PORT_IFU;
    if (req_ifu && req_lsu) begin
      grant = (last_q == PORT_LSU) ? PORT_IFU : PORT_LSU;
    end else if (req_lsu) begin
      grant = PORT_LSU;
    end
    gnt_valid = en && (req_ifu || req_lsu);
  end

  // Ready equals valid for the granted port, so every grant is an acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT_LSU;
    end else if (gnt_valid) begin
      last_q <= grant;
    end
  end

  assign last_grant = last_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-RAM arbiter for a fetch port and a load/store port: one outstanding
// access, response one cycle after acceptance, buffered while back-pressured.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = MEM_BASE_DEFAULT,
  parameter logic [31:0] MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  state_e      state_q, state_d;
  port_e       port_q, port_d;
  logic        fault_q, fault_d;
  logic        use_rd_q, use_rd_d;
  logic [31:0] buf_rdata_q, buf_rdata_d;
  logic        buf_err_q, buf_err_d;

  logic        arb_en;
  logic        gnt_valid;
  port_e       grant;
  port_e       last_grant;

  logic [31:0] sel_addr;
  logic [31:0] offset;
  logic        req_fault;
  logic        sel_rsp_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ifu_ready, lsu_ready;
  logic        ram_en;
  logic [3:0]  ram_we;

  assign arb_en = (state_q == IDLE) && !rst;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .en         (arb_en),
    .req_ifu    (bus.ifu_req_valid),
    .req_lsu    (bus.lsu_req_valid),
    .gnt_valid  (gnt_valid),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign sel_addr      = (grant == PORT_LSU) ? bus.lsu_addr : bus.ifu_addr;
  assign req_fault     = addr_fault(sel_addr, MEM_BASE, MEM_SIZE);
  assign offset        = sel_addr - MEM_BASE;
  assign sel_rsp_ready = (port_q == PORT_LSU) ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    fault_d     = fault_q;
    use_rd_d    = use_rd_q;
    buf_rdata_d = buf_rdata_q;
    buf_err_d   = buf_err_q;
    ifu_ready   = 1'b0;
    lsu_ready   = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 4'b0000;
    rsp_valid   = 1'b0;
    rsp_rdata   = 32'h0;
    rsp_err     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          ifu_ready = (grant == PORT_IFU);
          lsu_ready = (grant == PORT_LSU);
          if (!req_fault) begin
            ram_en = 1'b1;
            if (grant == PORT_LSU && bus.lsu_we) ram_we = bus.lsu_be;
          end
          port_d   = grant;
          fault_d  = req_fault;
          use_rd_d = !req_fault && !(grant == PORT_LSU && bus.lsu_we);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        rsp_valid = 1'b1;
        rsp_rdata = use_rd_q ? bus.ram_rd : 32'h0;
        rsp_err   = fault_q;
        if (sel_rsp_ready) begin
          state_d = IDLE;
        end else begin
          // ram_rd is only valid this cycle, so capture it before stalling.
          buf_rdata_d = rsp_rdata;
          buf_err_d   = fault_q;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        rsp_valid = 1'b1;
        rsp_rdata = buf_rdata_q;
        rsp_err   = buf_err_q;
        if (sel_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      port_q      <= PORT_IFU;
      fault_q     <= 1'b0;
      use_rd_q    <= 1'b0;
      buf_rdata_q <= 32'h0;
      buf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      fault_q     <= fault_d;
      use_rd_q    <= use_rd_d;
      buf_rdata_q <= buf_rdata_d;
      buf_err_q   <= buf_err_d;
    end
  end

  // Reset masks everything so an in-flight response never pulses out.
  assign bus.ifu_req_ready = ifu_ready && !rst;
  assign bus.lsu_req_ready = lsu_ready && !rst;
  assign bus.ifu_rsp_valid = rsp_valid && (port_q == PORT_IFU) && !rst;
  assign bus.lsu_rsp_valid = rsp_valid && (port_q == PORT_LSU) && !rst;
  assign bus.ifu_rdata     = (port_q == PORT_IFU) ? rsp_rdata : 32'h0;
  assign bus.lsu_rdata     = (port_q == PORT_LSU) ? rsp_rdata : 32'h0;
  assign bus.ifu_rsp_err   = rsp_err && (port_q == PORT_IFU);
  assign bus.lsu_rsp_err   = rsp_err && (port_q == PORT_LSU);
  assign bus.ram_en        = ram_en && !rst;
  assign bus.ram_we        = rst ? 4'b0000 : ram_we;
  assign bus.ram_addr      = {2'b00, offset[31:2]};
  assign bus.ram_wd        = bus.lsu_wdata;

endmodule
